// File: rtl/main_fsm_if.sv
// Control bundle between the multi-cycle main FSM and the datapath.
// The FSM side is the master; the datapath side is the slave.
interface main_fsm_if;
  logic [6:0]  op;
  logic        mem_ready;
  logic        PCUpdate;
  logic        Branch;
  logic        RegWrite;
  logic        MemWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic        illegal;
  logic [3:0]  state_o;
  logic [31:0] instret;

  modport master (
    input  op, mem_ready,
    output PCUpdate, Branch, RegWrite, MemWrite,
    output IRWrite, AdrSrc, ResultSrc, ALUSrcA,
    output ALUSrcB, ALUOp, illegal, state_o,
    output instret
  );

  modport slave (
    output op, mem_ready,
    input  PCUpdate, Branch, RegWrite, MemWrite,
    input  IRWrite, AdrSrc, ResultSrc, ALUSrcA,
    input  ALUSrcB, ALUOp, illegal, state_o,
    input  instret
  );
endinterface

// File: rtl/main_fsm.sv
// Multi-cycle RISC-V main control FSM with memory-ready waits,
// sticky illegal-opcode halt and retired-instruction counter.
module main_fsm (
  input logic        clk,
  input logic        reset_n,
  main_fsm_if.master bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    FAULT    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;
  logic        rdy;

  // Fetch enables must stay low while reset is held.
  assign rdy = bus.mem_ready & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.PCUpdate  = 1'b0;
    bus.Branch    = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ALUOp     = 2'b00;
    bus.illegal   = 1'b0;
    unique case (state_q)
      FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = rdy;
        bus.PCUpdate  = rdy;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        unique case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FAULT;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXECUTER: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        state_d = FETCH;
      end
      BEQ: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b01;
        bus.Branch  = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        bus.PCUpdate = 1'b1;
        state_d = ALUWB;
      end
      FAULT: begin
        bus.illegal = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    if (state_d == FETCH) begin
      retire = (state_q == MEMWB) || (state_q == MEMWRITE) ||
               (state_q == ALUWB) || (state_q == BEQ);
    end
    instret_d = instret_q + {31'd0, retire};
  end

  assign bus.state_o = state_q;
  assign bus.instret = instret_q;
endmodule

// File: doc/main_fsm.md
# main_fsm

Multi-cycle RISC-V main control FSM: sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the datapath multiplexer selects and write enables. Supplies the 2-bit ALUOp consumed by the ALU decoder directly downstream. Adds a memory-ready wait handshake, a sticky illegal-opcode halt and a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode, instruction bits [6:0], taken from the instruction register.
- mem_ready  in  1  memory access completes this cycle.
- PCUpdate  out  1  PC write enable.
- Branch  out  1  conditional PC write; qualified by Zero in the datapath.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write request.
- IRWrite  out  1  instruction register write enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode by funct3/funct7.
- illegal  out  1  high while halted in FAULT.
- state_o  out  4  current state encoding, for debug.
- instret  out  32  count of retired instructions.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5.
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, FAULT=11.
  - Codes 12-15 are unreachable; if entered, go to FETCH next cycle with all enables 0.
- Moore outputs decode from state. Any output not listed for a state is 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCUpdate=mem_ready. These two are gated by mem_ready so the PC increments exactly once.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - Next state by op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1100011 -> BEQ.
    - 1101111 -> JAL.
    - any other op -> FAULT.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op=lw -> MEMREAD; op=sw -> MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE:
  - ResultSrc=00, AdrSrc=1, MemWrite=1.
  - MemWrite stays high every cycle in this state until mem_ready=1, then go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- FAULT:
  - All enables 0, illegal=1.
  - Stays in FAULT until reset; mem_ready is ignored.
- instret:
  - Increments by 1 on each clock edge that moves the state into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Wraps from 0xFFFFFFFF to 0. Never increments on FAULT entry.
- op is sampled combinationally in DECODE and MEMADR only; it is don't-care in all other states.

## Timing
- Reset (reset_n low, asynchronous):
  - state = FETCH, instret = 0, illegal = 0.
  - IRWrite = PCUpdate = 0 regardless of mem_ready.
  - All other outputs take their FETCH values.
- Release of reset is synchronous to the next rising clk edge.
- Latency with mem_ready constantly 1, counted from FETCH through to the return to FETCH:
  - R-type and I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - jal: 4 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds 1 cycle.
- Reset asserted mid-instruction:
  - The FSM returns to FETCH immediately.
  - No pending RegWrite or MemWrite is asserted after reset_n falls.

## Test plan
- Reset, then mem_ready=1 and op=0110011: state_o sequence 0,1,6,8,0. ALUOp=10 in EXECUTER. RegWrite=1 in ALUWB only. instret=1 after the return to FETCH.
- op=0000011 with mem_ready low for 2 cycles in MEMREAD: sequence 0,1,2,3,3,3,4,0. AdrSrc=1 for all three MEMREAD cycles. ResultSrc=01 with RegWrite=1 in MEMWB.
- op=0100011 with mem_ready=0 for the first FETCH cycle: IRWrite=0 on that cycle, then 1 for one cycle. MemWrite=1 for exactly the MEMWRITE cycle(s). instret increments by 1.
- op=1100011, then op=1101111:
  - BEQ cycle drives Branch=1, ALUOp=01.
  - JAL cycle drives PCUpdate=1, ALUSrcA=01, ALUSrcB=10, then goes to ALUWB.
  - instret=2 after both.
- op=0000000 in DECODE: state_o=11, illegal=1 and all enables 0 held for 10 cycles. instret is unchanged. Asserting reset_n low clears illegal and sets state_o=0.
- Force instret to 0xFFFFFFFF, then run one addi: instret=0x00000000.
